// File: rtl/frontend_cmd_issue_queue.sv
// In-order command/write-data FIFO feeding the DDR3 backend over valid/ready,
// with a programmable write->read turnaround bubble. Optional issue counters: CMDQ_STATS_EN.
module frontend_cmd_issue_queue #(
  parameter int CMD_W    = 32,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 8,
  parameter int TURN_GAP = 4
) (
  input  logic                     clk,
  input  logic                     power_on_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [CMD_W-1:0]         i_req_command,
  input  logic                     i_req_is_read,
  input  logic [DATA_W-1:0]        i_req_write_data,
  output logic                     o_frontend_command_valid,
  input  logic                     i_backend_controller_ready,
  output logic [CMD_W-1:0]         o_frontend_command,
  output logic [DATA_W-1:0]        o_frontend_write_data,
`ifdef CMDQ_STATS_EN
  output logic [15:0]              o_rd_issued_cnt,
  output logic [15:0]              o_wr_issued_cnt,
`endif
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam bit HAS_GAP = (TURN_GAP != 0);
  localparam logic [3:0] GAP_INIT = (TURN_GAP == 0) ? 4'd0 : 4'(TURN_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          last_is_read_q, last_is_read_d;

  logic [CMD_W-1:0]  cmd_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              dir_mem  [DEPTH];

  logic [AW-1:0] wr_idx, rd_idx, rd_next_idx;
  logic          full, empty, push, pop;
  logic          head_is_read, next_is_read;

  assign wr_idx      = wr_ptr_q[AW-1:0];
  assign rd_idx      = rd_ptr_q[AW-1:0];
  assign rd_next_idx = rd_idx + 1'b1;

  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Ready is held low for the whole reset window, not just until the first edge.
  assign o_req_ready = !full && !power_on_rst;
  assign push        = i_req_valid && o_req_ready;

  assign o_frontend_command_valid = (state_q == ST_ISSUE);
  assign pop                      = o_frontend_command_valid && i_backend_controller_ready;

  assign o_frontend_command    = cmd_mem[rd_idx];
  assign o_frontend_write_data = data_mem[rd_idx];
  assign head_is_read          = dir_mem[rd_idx];

  // Entry that becomes head after a pop: the stored successor, or the one being pushed now.
  assign next_is_read = (count_q > PW'(1)) ? dir_mem[rd_next_idx] : i_req_is_read;

  assign o_count = count_q;

  // NOTE: storage has no reset; only the pointers define which entries are live,
  // so a reset on the arrays would cost a mux per bit for no functional gain.
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_idx]  <= i_req_command;
      data_mem[wr_idx] <= i_req_write_data;
      dir_mem[wr_idx]  <= i_req_is_read;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    last_is_read_d = last_is_read_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d       = rd_ptr_q + 1'b1;
      last_is_read_d = head_is_read;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (HAS_GAP && head_is_read && !last_is_read_q) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_INIT;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (push) begin
          // Pushed entry is the next head; decide its turnaround now so it is offered next cycle.
          if (HAS_GAP && i_req_is_read && !last_is_read_q) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_INIT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (pop) begin
          if ((count_q == PW'(1)) && !push) begin
            state_d = ST_IDLE;
          end else if (HAS_GAP && next_is_read && !head_is_read) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_INIT;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) state_d = ST_ISSUE;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      state_q        <= ST_IDLE;
      gap_cnt_q      <= 4'd0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      last_is_read_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      last_is_read_q <= last_is_read_d;
    end
  end

`ifdef CMDQ_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (pop && head_is_read && (rd_cnt_q != 16'hFFFF))  rd_cnt_d = rd_cnt_q + 16'd1;
    if (pop && !head_is_read && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign o_rd_issued_cnt = rd_cnt_q;
  assign o_wr_issued_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_frontend_cmd_issue_queue.sv
// Directed bench for frontend_cmd_issue_queue: queue-level reference model compared every
// cycle, plus literal checks for each scenario. Stats scenario runs when CMDQ_STATS_EN is defined.
module tb_frontend_cmd_issue_queue;

  localparam int CMD_W    = 32;
  localparam int DATA_W   = 64;
  localparam int DEPTH    = 8;
  localparam int TURN_GAP = 4;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_read = 1'b0;
  logic [CMD_W-1:0]  in_cmd = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              be_ready = 1'b0;
  logic              req_ready;
  logic              cmd_valid;
  logic [CMD_W-1:0]  head_cmd;
  logic [DATA_W-1:0] head_data;
  logic [CW-1:0]     count;
`ifdef CMDQ_STATS_EN
  logic [15:0]       rd_issued;
  logic [15:0]       wr_issued;
`endif

  int tests = 0;
  int fails = 0;

  frontend_cmd_issue_queue #(
    .CMD_W(CMD_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TURN_GAP(TURN_GAP)
  ) dut (
    .clk                        (clk),
    .power_on_rst               (rst),
    .i_req_valid                (in_valid),
    .o_req_ready                (req_ready),
    .i_req_command              (in_cmd),
    .i_req_is_read              (in_read),
    .i_req_write_data           (in_data),
    .o_frontend_command_valid   (cmd_valid),
    .i_backend_controller_ready (be_ready),
    .o_frontend_command         (head_cmd),
    .o_frontend_write_data      (head_data),
`ifdef CMDQ_STATS_EN
    .o_rd_issued_cnt            (rd_issued),
    .o_wr_issued_cnt            (wr_issued),
`endif
    .o_count                    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input logic [CMD_W-1:0] c);
    return {c ^ 32'hDA7A_5EED, ~c};
  endfunction

  // Reference model: a plain queue, the last popped direction and a bubble countdown
  // that starts whenever a read reaches the head right after a write left.
  typedef struct {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
    bit                rd;
  } ent_t;

  ent_t q[$];
  bit   m_last_rd = 1'b1;
  int   m_bubble  = 0;
  int   m_rd_cnt  = 0;
  int   m_wr_cnt  = 0;

  always @(posedge clk or posedge rst) begin : model
    int  sz;
    bit  m_valid, do_push, do_pop, head_changed;
    ent_t e;
    if (rst) begin
      q.delete();
      m_last_rd = 1'b1;
      m_bubble  = 0;
      m_rd_cnt  = 0;
      m_wr_cnt  = 0;
    end else begin
      sz           = q.size();
      m_valid      = (sz > 0) && (m_bubble == 0);
      do_push      = in_valid && (sz < DEPTH);
      do_pop       = m_valid && be_ready;
      head_changed = do_pop || (do_push && sz == 0);
      if (do_pop) begin
        m_last_rd = q[0].rd;
        if (q[0].rd) begin
          if (m_rd_cnt < 65535) m_rd_cnt++;
        end else begin
          if (m_wr_cnt < 65535) m_wr_cnt++;
        end
        void'(q.pop_front());
      end
      if (do_push) begin
        e.cmd  = in_cmd;
        e.data = in_data;
        e.rd   = in_read;
        q.push_back(e);
      end
      if (m_bubble > 0) m_bubble--;
      if (head_changed && q.size() > 0 && q[0].rd && !m_last_rd) m_bubble = TURN_GAP;
    end
  end

  always @(negedge clk) begin : compare
    bit exp_valid;
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_valid", cmd_valid, 0);
      check("rst_count", count, 0);
    end else begin
      exp_valid = (q.size() > 0) && (m_bubble == 0);
      check("req_ready", req_ready, (q.size() < DEPTH) ? 1 : 0);
      check("count", count, q.size());
      check("valid", cmd_valid, exp_valid);
      if (exp_valid && cmd_valid) begin
        check("head_cmd", head_cmd, q[0].cmd);
        check("head_data", head_data, q[0].data);
      end
`ifdef CMDQ_STATS_EN
      check("rd_issued", rd_issued, m_rd_cnt);
      check("wr_issued", wr_issued, m_wr_cnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic [CMD_W-1:0] c);
    in_valid = v;
    in_read  = rd;
    in_cmd   = c;
    in_data  = mk_data(c);
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    check("init_ready", req_ready, 0);
    check("init_valid", cmd_valid, 0);
    check("init_count", count, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // 1: fill with 8 writes, 9th refused
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 32'(100 + i));
      tick();
    end
    drive(1'b0, 1'b0, '0);
    check("t1_count", count, 8);
    check("t1_ready", req_ready, 0);
    check("t1_valid", cmd_valid, 1);
    check("t1_head", head_cmd, 100);
    check("t1_data", head_data, mk_data(100));

    // 2: drain back-to-back, order preserved
    be_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t2_valid", cmd_valid, 1);
      check("t2_head", head_cmd, 32'(100 + k));
      tick();
    end
    check("t2_count", count, 0);
    check("t2_valid_after", cmd_valid, 0);
    be_ready = 1'b0;

    // 3: write then read, exactly TURN_GAP idle cycles between
    drive(1'b1, 1'b0, 200); tick();
    drive(1'b1, 1'b1, 201); tick();
    drive(1'b0, 1'b0, '0);
    check("t3_wr_valid", cmd_valid, 1);
    check("t3_wr_head", head_cmd, 200);
    be_ready = 1'b1;
    tick();
    for (int j = 1; j <= TURN_GAP; j++) begin
      check("t3_gap_valid", cmd_valid, 0);
      tick();
    end
    check("t3_rd_valid", cmd_valid, 1);
    check("t3_rd_head", head_cmd, 201);
    tick();
    be_ready = 1'b0;

    // 4: read, write, write issue with no bubble
    drive(1'b1, 1'b1, 300); tick();
    drive(1'b1, 1'b0, 301); tick();
    drive(1'b1, 1'b0, 302); tick();
    drive(1'b0, 1'b0, '0);
    be_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t4_valid", cmd_valid, 1);
      check("t4_head", head_cmd, 32'(300 + k));
      tick();
    end
    check("t4_count", count, 0);
    be_ready = 1'b0;

    // 5: full queue, push+pop same cycle -> push refused
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 32'(400 + i));
      tick();
    end
    drive(1'b1, 1'b0, 499);
    be_ready = 1'b1;
    check("t5_ready_full", req_ready, 0);
    tick();
    drive(1'b0, 1'b0, '0);
    be_ready = 1'b0;
    check("t5_count", count, 7);
    check("t5_ready", req_ready, 1);
    check("t5_head", head_cmd, 401);
    be_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      check("t5_drain", head_cmd, 32'(401 + k));
      tick();
    end
    check("t5_empty", count, 0);
    be_ready = 1'b0;

    // 6: reset during GAP with 5 entries queued
    drive(1'b1, 1'b0, 500); tick();
    for (int i = 1; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'(500 + i));
      tick();
    end
    drive(1'b1, 1'b0, 505); tick();
    drive(1'b0, 1'b0, '0);
    be_ready = 1'b1;
    tick();
    be_ready = 1'b0;
    check("t6_pre_count", count, 5);
    check("t6_in_gap", cmd_valid, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", cmd_valid, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_ready", req_ready, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    drive(1'b1, 1'b0, 600); tick();
    drive(1'b0, 1'b0, '0);
    check("t6_post_valid", cmd_valid, 1);
    check("t6_post_head", head_cmd, 600);
    check("t6_post_count", count, 1);
    be_ready = 1'b1;
    tick();
    be_ready = 1'b0;
    check("t6_post_empty", count, 0);

`ifdef CMDQ_STATS_EN
    be_ready = 1'b1;
    for (int i = 0; i < 70010; i++) begin
      drive(1'b1, 1'b1, 32'(1000 + i));
      tick();
    end
    drive(1'b0, 1'b0, '0);
    repeat (4) tick();
    be_ready = 1'b0;
    check("stats_rd_sat", rd_issued, 16'hFFFF);
    check("stats_wr", wr_issued, 1);
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
